// File: rtl/display_pkg.sv
// Shared constants for the segment display path: segment patterns,
// special digit positions and the shift-register width.
package display_pkg;

  // 7-segment patterns, bit order g,f,e,d,c,b,a (a = bit 0)
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Digit positions with special treatment
  localparam logic [2:0] DIGIT_HOURS_TENS = 3'd5;
  localparam logic [2:0] COLON_DIGIT_A    = 3'd2;
  localparam logic [2:0] COLON_DIGIT_B    = 3'd4;

  // Bits per digit in the external shift chain
  localparam int SR_BITS = 8;

  // BCD digit to segment pattern; non-decimal codes are blank
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to display byte: segments, decimal point,
// whole-byte blanking and optional polarity inversion.
module seg7_decode #(
  parameter bit SEG_INVERT = 1'b0
) (
  input  logic [3:0] digit,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg_byte
);
  import display_pkg::*;

  logic [7:0] raw_byte;

  // Build the active-high byte, then apply output polarity
  always_comb begin
    raw_byte = 8'h00;
    if (!blank) raw_byte = {dp, seg_pattern(digit)};
    seg_byte = raw_byte ^ {8{SEG_INVERT}};
  end

endmodule

// File: rtl/segment_serializer.sv
// Serializes decoded time digits into a 74HC595-style chain, driven by the
// display controller's load/shift slot sequence. Holds a tear-free snapshot
// of the time that only changes at a frame-start load, and flags framing
// errors in the controller's sequence.
//
// Handshake: there is no back-pressure. shift_en marks one serial slot;
// when sr_load is also high the slot loads digit bcd_select, otherwise it
// shifts one bit. time_valid is a one-cycle pulse that is always accepted.
module segment_serializer #(
  parameter int NUM_DIGITS    = 6,
  parameter bit SEG_INVERT    = 1'b0,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_en,
  input  logic        sr_load,
  input  logic [2:0]  bcd_select,
  input  logic [23:0] time_bcd,
  input  logic        colon,
  input  logic        time_valid,
  output logic        serial_out,
  output logic        frame_start,
  output logic        frame_error
);
  import display_pkg::*;

  localparam logic INV_BIT = SEG_INVERT;

  logic        load, frame_load, use_pending;
  logic [24:0] src_vec;
  logic [3:0]  sel_digit;
  logic        sel_legal, dp, blank;
  logic [7:0]  dec_byte;

  logic [24:0] pending_q, pending_d;
  logic        pending_flag_q, pending_flag_d;
  logic [24:0] snap_q, snap_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        seen_load_q, seen_load_d;
  logic [2:0]  prev_idx_q, prev_idx_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_error_q, frame_error_d;

  // Pick the digit to load; a committing frame start decodes the fresh value
  always_comb begin
    load        = shift_en & sr_load;
    frame_load  = load & (bcd_select == 3'd0);
    use_pending = frame_load & pending_flag_q;
    src_vec     = use_pending ? pending_q : snap_q;
    sel_legal   = ({29'd0, bcd_select} < NUM_DIGITS);
    sel_digit   = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ({29'd0, bcd_select} == k) sel_digit = src_vec[4*k +: 4];
    end
    dp    = src_vec[24] & ((bcd_select == COLON_DIGIT_A) | (bcd_select == COLON_DIGIT_B));
    blank = ~sel_legal |
            (BLANK_LEADING & (bcd_select == DIGIT_HOURS_TENS) & (sel_digit == 4'd0));
  end

  seg7_decode #(
    .SEG_INVERT (SEG_INVERT)
  ) u_seg7_decode (
    .digit    (sel_digit),
    .dp       (dp),
    .blank    (blank),
    .seg_byte (dec_byte)
  );

  // Capture new time into pending; move it to the snapshot at frame start.
  // A coinciding time_valid lands after the commit, so it stays pending.
  always_comb begin
    pending_d      = pending_q;
    pending_flag_d = pending_flag_q;
    snap_d         = snap_q;
    if (use_pending) begin
      snap_d         = pending_q;
      pending_flag_d = 1'b0;
    end
    if (time_valid) begin
      pending_d      = {colon, time_bcd};
      pending_flag_d = 1'b1;
    end
  end

  // Load/shift datapath plus frame start and sequencing checks
  always_comb begin
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    seen_load_d   = seen_load_q;
    prev_idx_d    = prev_idx_q;
    frame_start_d = 1'b0;
    frame_error_d = 1'b0;
    if (load) begin
      shreg_d       = dec_byte;
      bit_cnt_d     = 4'd0;
      seen_load_d   = 1'b1;
      prev_idx_d    = bcd_select;
      frame_start_d = frame_load;
      frame_error_d = (seen_load_q & (bit_cnt_q != 4'(SR_BITS))) |
                      ~sel_legal |
                      (seen_load_q & (bcd_select != 3'd0) &
                       (bcd_select != prev_idx_q + 3'd1));
    end else if (shift_en) begin
      shreg_d   = {shreg_q[6:0], INV_BIT};
      bit_cnt_d = (bit_cnt_q == 4'hF) ? 4'hF : bit_cnt_q + 4'd1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= '0;
      pending_flag_q <= 1'b0;
      snap_q         <= '0;
      shreg_q        <= {8{INV_BIT}};
      bit_cnt_q      <= 4'd0;
      seen_load_q    <= 1'b0;
      prev_idx_q     <= 3'd0;
      frame_start_q  <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      pending_flag_q <= pending_flag_d;
      snap_q         <= snap_d;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      seen_load_q    <= seen_load_d;
      prev_idx_q     <= prev_idx_d;
      frame_start_q  <= frame_start_d;
      frame_error_q  <= frame_error_d;
    end
  end

  assign serial_out  = shreg_q[SR_BITS-1];
  assign frame_start = frame_start_q;
  assign frame_error = frame_error_q;

endmodule
